uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Byte buffer placed directly upstream of the UART transmitter. Accepts bytes from the CPU/IO bus with a single-cycle write strobe, stores them in a circular FIFO, and feeds them one at a time into the transmitter through its go/bsy handshake. Data is held stable for the whole frame, so the CPU never stalls on an individual UART byte.

## Interface
- `Depth`, 16, number of FIFO entries; power of two, at least 2.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `wr_data`  in  8  byte to enqueue.
- `wr_en`  in  1  enqueue strobe, sampled on rising `clk`.
- `full`  out  1  FIFO holds `Depth` entries.
- `empty`  out  1  FIFO holds 0 entries.
- `level`  out  $clog2(Depth)+1  current entry count.
- `tx_data`  out  8  byte presented to the transmitter's `data` input.
- `tx_go`  out  1  transmitter `go` request.
- `tx_bsy`  in  1  transmitter `bsy` status.
- `overflow`  out  1  sticky: a write was dropped. Present only with `UART_TX_FIFO_OVERFLOW_EN`.

## Operation
- Storage: `Depth` x 8 array, write pointer, read pointer, and count register. All are registered, so `full`, `empty` and `level` are derived from the count.
- Write: `wr_en` with `!full` stores `wr_data` at the write pointer, then increments the pointer and the count.
- Write while `full` is dropped and leaves the contents unchanged, even if a pop occurs on the same edge.
- Pointers wrap modulo `Depth` with natural binary overflow of `$clog2(Depth)` bits.
- Pop happens only in state Release. A pop and a write on the same edge leave the count unchanged; both pointers advance.
- Handshake FSM. States are Idle, WaitBsy, WaitDone, Release and Gap.
  - Idle: if `!empty`, load `tx_data` from the read-pointer entry and set `tx_go` to 1; go to WaitBsy.
  - WaitBsy: hold `tx_go`=1 until `tx_bsy`=1; go to WaitDone.
  - WaitDone: hold `tx_go`=1 until `tx_bsy`=0 (frame finished); set `tx_go` to 0, pop the entry, go to Release.
  - Release: go to Gap. `tx_go` stays 0.
  - Gap: go to Idle. This guarantees `tx_go` is low for at least 2 cycles, so the transmitter leaves its wait-for-go-low state before the next request.
- `tx_data` is a register. It changes only on the Idle→WaitBsy transition and is stable while `tx_go`=1.
- Reset, asynchronous, including mid-frame:
  - count, pointers, `tx_go`, `tx_data` and `overflow` go to 0; state goes to Idle.
  - Consequently `empty`=1, `full`=0 and `level`=0.
  - Queued bytes are discarded. The transmitter shares `rst_n` and is reset together with this block.

## Timing
- First byte latency: `wr_en` sampled on edge k into an empty FIFO in Idle gives `level`=1 after k. `tx_go` rises and `tx_data` is valid after edge k+1.
- Throughput: one byte per UART frame, plus 3 cycles of handshake overhead (Release, Gap, Idle).
- `full` and `empty` update on the same edge as the write or pop that changes the count.
- `wr_en` has no ready/ack. The writer must check `full` before writing.

## Configuration
- Macro: `UART_TX_FIFO_OVERFLOW_EN`.
- Defined:
  - The `overflow` port exists.
  - It is set on any `wr_en` while `full`.
  - It stays set until reset.
- Undefined: the port and its register are absent, and dropped writes are silent.

## Structure
- Shared package `uart_pkg` contains:
  - the FSM state enum `uart_tx_fifo_state_e`;
  - the constant `UartDataWidth` = 8.
- One sub-module, `fifo_mem`:
  - `Depth` x 8 register array;
  - synchronous write port;
  - asynchronous read of the read-pointer entry.
- Pointer, count, and FSM logic stay in `uart_tx_fifo`.

## Test plan
- Single byte: write 0x55 into the empty FIFO, with a transmitter model asserting `bsy` 1 cycle after `go` for 100 cycles.
  - `tx_go` rises 2 edges after the write, with `tx_data`=0x55.
  - After `bsy` falls, `tx_go` falls, then `empty`=1.
- Burst ordering: write 0x01..0x05 on consecutive cycles → the transmitter model receives exactly 0x01,0x02,0x03,0x04,0x05 in order, with `tx_go` low at least 2 cycles between requests.
- Full and drop: with `tx_bsy` held low, write `Depth`+1 bytes (0x10..0x20).
  - `full`=1 and `level`=16.
  - 0x20 is dropped, and `overflow`=1 when the macro is defined.
  - Draining yields 0x10..0x1F.
- Simultaneous write and pop at full: a write on the Release edge is dropped, `level` goes 16→15, and the next write is accepted.
- Wrap-around: push and drain 40 bytes with random gaps → output matches input, and `level` returns to 0.
- Reset mid-frame: assert `rst_n`=0 while in WaitDone with 3 bytes queued.
  - Immediately `tx_go`=0, `level`=0 and `empty`=1, without a clock edge.
  - After release, no transmission starts until a new write.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: byte width and the
// go/bsy handshake state encoding used by uart_tx_fifo.
package uart_pkg;

    localparam int UartDataWidth = 8;

    typedef enum logic [2:0] {
        Idle,
        WaitBsy,
        WaitDone,
        Release,
        Gap
    } uart_tx_fifo_state_e;

endpackage

// File: rtl/fifo_mem.sv
// Depth x byte register array with a synchronous write port and an
// asynchronous read port addressed by the FIFO read pointer.
module fifo_mem
    import uart_pkg::*;
#(
    parameter  int Depth = 16,
    localparam int AddrW = $clog2(Depth)
) (
    input  logic                     clk_i,
    input  logic                     wr_en_i,
    input  logic [AddrW-1:0]         wr_addr_i,
    input  logic [UartDataWidth-1:0] wr_data_i,
    input  logic [AddrW-1:0]         rd_addr_i,
    output logic [UartDataWidth-1:0] rd_data_o
);

    logic [UartDataWidth-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding a UART transmitter through its go/bsy handshake.
// Define UART_TX_FIFO_OVERFLOW_EN to add the sticky overflow output.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int Depth = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [UartDataWidth-1:0] wr_data,
    input  logic                     wr_en,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   level,
    output logic [UartDataWidth-1:0] tx_data,
    output logic                     tx_go,
    input  logic                     tx_bsy
`ifdef UART_TX_FIFO_OVERFLOW_EN
    ,
    output logic                     overflow
`endif
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;

    logic [PtrW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]          count_q, count_d;
    logic                     wr_accept;
    logic                     pop;
    logic [UartDataWidth-1:0] rd_data;
    uart_tx_fifo_state_e      state_q;
    logic                     tx_go_q;
    logic [UartDataWidth-1:0] tx_data_q;

    assign full  = (count_q == CntW'(Depth));
    assign empty = (count_q == '0);
    assign level = count_q;

    // A write at full is dropped even when the same edge pops an entry.
    assign wr_accept = wr_en && !full;
    assign pop       = (state_q == Release);

    always_comb begin
        wr_ptr_d = wr_accept ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({wr_accept, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    fifo_mem #(
        .Depth(Depth)
    ) u_mem (
        .clk_i    (clk),
        .wr_en_i  (wr_accept),
        .wr_addr_i(wr_ptr_q),
        .wr_data_i(wr_data),
        .rd_addr_i(rd_ptr_q),
        .rd_data_o(rd_data)
    );

    // Release and Gap keep go low for two cycles so the transmitter can
    // leave its wait-for-go-low state before the next request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= Idle;
            tx_go_q   <= 1'b0;
            tx_data_q <= '0;
        end else begin
            case (state_q)
                Idle: begin
                    if (!empty) begin
                        tx_data_q <= rd_data;
                        tx_go_q   <= 1'b1;
                        state_q   <= WaitBsy;
                    end
                end
                WaitBsy: begin
                    if (tx_bsy) begin
                        state_q <= WaitDone;
                    end
                end
                WaitDone: begin
                    if (!tx_bsy) begin
                        tx_go_q <= 1'b0;
                        state_q <= Release;
                    end
                end
                Release: state_q <= Gap;
                Gap:     state_q <= Idle;
                default: begin
                    tx_go_q <= 1'b0;
                    state_q <= Idle;
                end
            endcase
        end
    end

    assign tx_go   = tx_go_q;
    assign tx_data = tx_data_q;

`ifdef UART_TX_FIFO_OVERFLOW_EN
    logic overflow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (wr_en && full) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: a transmitter model answers go/bsy,
// expected bytes are queued at write time and checked when tx_go rises.
module tb_uart_tx_fifo;

    localparam int Depth = 16;

    logic                 clk;
    logic                 rst_n;
    logic [7:0]           wr_data;
    logic                 wr_en;
    logic                 full;
    logic                 empty;
    logic [$clog2(Depth):0] level;
    logic [7:0]           tx_data;
    logic                 tx_go;
    logic                 tx_bsy;
`ifdef UART_TX_FIFO_OVERFLOW_EN
    logic                 overflow;
`endif

    int testsRun    = 0;
    int testsFailed = 0;

    logic [7:0] expQ [$];
    bit         txModelOn = 0;
    int         frameLen  = 8;

    uart_tx_fifo #(
        .Depth(Depth)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_data (wr_data),
        .wr_en   (wr_en),
        .full    (full),
        .empty   (empty),
        .level   (level),
        .tx_data (tx_data),
        .tx_go   (tx_go),
        .tx_bsy  (tx_bsy)
`ifdef UART_TX_FIFO_OVERFLOW_EN
        ,
        .overflow(overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One write strobe; bytes the writer expects to be accepted are queued.
    task automatic applyStimulus(input logic [7:0] data, input bit accept);
        wr_data = data;
        wr_en   = 1'b1;
        if (accept) expQ.push_back(data);
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic waitDrain(input string name, input int bound);
        bit done = 0;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk); #1;
            if (empty && expQ.size() == 0) begin
                done = 1;
                break;
            end
        end
        checkOutput(name, 32'(done), 32'd1);
        waitCycles(3);
    endtask

    // Transmitter model: raise bsy after go, hold it frameLen cycles, then
    // wait for go to drop before accepting another request.
    initial begin
        int  frameCnt = 0;
        bit  waitLow  = 0;
        tx_bsy = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                tx_bsy   = 1'b0;
                frameCnt = 0;
                waitLow  = 0;
            end else if (!txModelOn) begin
                tx_bsy = 1'b0;
            end else if (tx_bsy) begin
                if (frameCnt <= 1) begin
                    tx_bsy  = 1'b0;
                    waitLow = 1;
                end else begin
                    frameCnt--;
                end
            end else if (waitLow) begin
                if (!tx_go) waitLow = 0;
            end else if (tx_go) begin
                tx_bsy   = 1'b1;
                frameCnt = frameLen;
            end
        end
    end

    // Monitor: each rising tx_go must carry the next queued byte, follow at
    // least two low cycles, and hold tx_data steady while go stays high.
    initial begin
        bit         prevGo = 0;
        int         lowCnt = 100;
        logic [7:0] heldData = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prevGo = 0;
                lowCnt = 100;
            end else begin
                if (tx_go && !prevGo) begin
                    if (expQ.size() == 0) begin
                        testsRun++;
                        testsFailed++;
                        $display("[TB] FAIL unexpected_go: got tx_data 0x%0h, expected no request", tx_data);
                    end else begin
                        checkOutput("tx_data_order", 32'(tx_data), 32'(expQ.pop_front()));
                    end
                    checkOutput("go_low_gap_ok", 32'(lowCnt >= 2), 32'd1);
                    heldData = tx_data;
                end else if (tx_go && prevGo) begin
                    checkOutput("tx_data_stable", 32'(tx_data), 32'(heldData));
                end
                lowCnt = tx_go ? 0 : lowCnt + 1;
                prevGo = tx_go;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit found;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;

        #3;
        checkOutput("reset_empty", 32'(empty), 32'd1);
        checkOutput("reset_full", 32'(full), 32'd0);
        checkOutput("reset_level", 32'(level), 32'd0);
        checkOutput("reset_tx_go", 32'(tx_go), 32'd0);
        waitCycles(2);
        rst_n = 1'b1;
        waitCycles(2);

        $display("[TB] single byte");
        txModelOn = 1;
        frameLen  = 100;
        applyStimulus(8'h55, 1);
        checkOutput("single_level_after_write", 32'(level), 32'd1);
        checkOutput("single_go_not_yet", 32'(tx_go), 32'd0);
        waitCycles(1);
        checkOutput("single_go_rise", 32'(tx_go), 32'd1);
        checkOutput("single_tx_data", 32'(tx_data), 32'h55);
        found = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (!tx_go) begin
                found = 1;
                break;
            end
        end
        checkOutput("single_go_fall_seen", 32'(found), 32'd1);
        checkOutput("single_not_popped_yet", 32'(empty), 32'd0);
        waitCycles(1);
        checkOutput("single_empty_after_pop", 32'(empty), 32'd1);
        checkOutput("single_level_after_pop", 32'(level), 32'd0);
        waitCycles(3);

        $display("[TB] burst ordering");
        frameLen = 6;
        for (int i = 1; i <= 5; i++) applyStimulus(8'(i), 1);
        waitDrain("burst_drained", 500);
        checkOutput("burst_level_zero", 32'(level), 32'd0);

        $display("[TB] full and drop");
        txModelOn = 0;
        for (int i = 0; i <= Depth; i++) applyStimulus(8'(8'h10 + i), i < Depth);
        checkOutput("full_flag", 32'(full), 32'd1);
        checkOutput("full_level", 32'(level), 32'd16);
        checkOutput("full_not_empty", 32'(empty), 32'd0);
`ifdef UART_TX_FIFO_OVERFLOW_EN
        checkOutput("overflow_set", 32'(overflow), 32'd1);
`endif

        $display("[TB] write on release edge at full");
        txModelOn = 1;
        frameLen  = 4;
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (!tx_go) begin
                found = 1;
                break;
            end
        end
        checkOutput("release_go_fall_seen", 32'(found), 32'd1);
        applyStimulus(8'hA0, 0);
        checkOutput("release_level_15", 32'(level), 32'd15);
        checkOutput("release_not_full", 32'(full), 32'd0);
        applyStimulus(8'hA1, 1);
        checkOutput("release_next_write_level", 32'(level), 32'd16);
        waitDrain("full_drained", 3000);
        checkOutput("full_drain_level_zero", 32'(level), 32'd0);
`ifdef UART_TX_FIFO_OVERFLOW_EN
        checkOutput("overflow_sticky", 32'(overflow), 32'd1);
`endif

        $display("[TB] wrap-around");
        frameLen = 3;
        for (int i = 0; i < 40; i++) begin
            found = 0;
            for (int w = 0; w < 200; w++) begin
                if (!full) begin
                    found = 1;
                    break;
                end
                @(posedge clk); #1;
            end
            if (!found) checkOutput("wrap_space_timeout", 32'(full), 32'd0);
            applyStimulus(8'(8'h30 + 7 * i), 1);
            waitCycles($urandom_range(0, 3));
        end
        waitDrain("wrap_drained", 3000);
        checkOutput("wrap_level_zero", 32'(level), 32'd0);

        $display("[TB] reset mid-frame");
        frameLen = 50;
        applyStimulus(8'hC1, 1);
        applyStimulus(8'hC2, 1);
        applyStimulus(8'hC3, 1);
        found = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (tx_bsy) begin
                found = 1;
                break;
            end
        end
        checkOutput("midframe_bsy_seen", 32'(found), 32'd1);
        waitCycles(2);
        checkOutput("midframe_go_high", 32'(tx_go), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_go", 32'(tx_go), 32'd0);
        checkOutput("async_reset_level", 32'(level), 32'd0);
        checkOutput("async_reset_empty", 32'(empty), 32'd1);
        expQ.delete();
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        waitCycles(20);
        checkOutput("post_reset_no_go", 32'(tx_go), 32'd0);
        checkOutput("post_reset_level", 32'(level), 32'd0);
`ifdef UART_TX_FIFO_OVERFLOW_EN
        checkOutput("post_reset_overflow", 32'(overflow), 32'd0);
`endif
        applyStimulus(8'h77, 1);
        waitDrain("post_reset_drained", 300);
        checkOutput("post_reset_final_level", 32'(level), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
